// File: rtl/bcd_seg_scanner_if.sv
// Bus between a digit source and the 7-segment scanner.
// Parameter: NUM_DIGITS - number of packed BCD digits carried on bcd_in.
// Signals:
//   bcd_in     packed digits, digit k = bcd_in[4k+3:4k] (source -> scanner)
//   load       capture strobe for bcd_in (source -> scanner)
//   blank      force all digit enables off (source -> scanner)
//   seg        {g,f,e,d,c,b,a} active-high (scanner -> source)
//   an         one-hot digit enable, active-high (scanner -> source)
//   frame_done one-cycle pulse at each scan wrap (scanner -> source)
//   err        sticky flag, a non-BCD nibble was loaded (scanner -> source)
// Modports: master = digit source / test driver, slave = scanner.
interface bcd_seg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    load;
  logic                    blank;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
  logic                    err;

  modport master (
    output bcd_in, load, blank,
    input  seg, an, frame_done, err
  );

  modport slave (
    input  bcd_in, load, blank,
    output seg, an, frame_done, err
  );
endinterface

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 7-segment scanner for packed BCD digits.
// Captures digits into a shadow register on load, and copies the shadow into
// the displayed frame only when the scan wraps back to digit 0, so a frame is
// never shown half old / half new.
// Parameters:
//   NUM_DIGITS  - digits scanned (>=1), digit 0 least significant
//   REFRESH_DIV - clk cycles each digit stays enabled (>=1)
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-low
//   bus   - bcd_seg_scanner_if.slave (bcd_in/load/blank in; seg/an/frame_done/err out)
// Optional feature macro: LEADING_ZERO_BLANK_EN - when defined, digits above
// the highest nonzero frame digit are not enabled (digit 0 always shown).
module bcd_seg_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  bcd_seg_scanner_if.slave   bus
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [DATA_W-1:0]     shadow;
  logic [DATA_W-1:0]     frame;
  logic [CNT_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;

  logic                  slot_end_c;
  logic                  wrap_c;
  logic [3:0]            cur_digit_c;
  logic [6:0]            seg_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic                  bad_nibble_c;

  // BCD to {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Slot timing: end of the current digit slot, and end of the whole frame.
  always_comb begin
    slot_end_c = (div_cnt == CNT_LAST);
    wrap_c     = slot_end_c && (idx == IDX_LAST);
  end

  // Digit currently addressed by the scan and its segment pattern.
  always_comb begin
    cur_digit_c = 4'd0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx == IDX_W'(k)) cur_digit_c = frame[4*k +: 4];
    end
    seg_c = seg_decode(cur_digit_c);
  end

  // Digit enable: one-hot of idx, optionally masked for leading zeros, then blank.
  always_comb begin
    an_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      an_c[k] = (idx == IDX_W'(k));
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic nz_seen;
      nz_seen = 1'b0;
      // Walk from the top digit down; a digit is shown once a nonzero digit
      // has been seen at or above it.
      for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
        nz_seen = nz_seen | (frame[4*k +: 4] != 4'd0);
        if (!nz_seen) an_c[k] = 1'b0;
      end
    end
`endif
    if (bus.blank) an_c = '0;
  end

  // Any nibble of the incoming word outside 0-9.
  always_comb begin
    bad_nibble_c = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (bus.bcd_in[4*k +: 4] > 4'd9) bad_nibble_c = 1'b1;
    end
  end

  // Scan counters, shadow/frame registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow         <= '0;
      frame          <= '0;
      div_cnt        <= '0;
      idx            <= '0;
      bus.seg        <= '0;
      bus.an         <= '0;
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      div_cnt <= slot_end_c ? '0 : div_cnt + CNT_W'(1);
      if (slot_end_c) idx <= wrap_c ? '0 : idx + IDX_W'(1);
      // frame takes the pre-edge shadow, so a coincident load lands next frame.
      if (wrap_c) frame <= shadow;
      if (bus.load) begin
        shadow <= bus.bcd_in;
        if (bad_nibble_c) bus.err <= 1'b1;
      end
      bus.frame_done <= wrap_c;
      bus.an         <= an_c;
      bus.seg        <= seg_c;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner (NUM_DIGITS=4, REFRESH_DIV=4).
// Directed steps followed by randomized load/blank traffic, all compared each
// cycle against a reference model written in terms of elapsed cycles since
// reset release. Define LEADING_ZERO_BLANK_EN to exercise the optional mask.
module tb_bcd_seg_scanner;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  bcd_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_seg_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release, captured words, sticky err.
  int          m_e;
  logic [15:0] m_shadow;
  logic [15:0] m_frame;
  logic        m_err;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;
  logic        e_err;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;  4'd3: s = 7'h4F;
      4'd4: s = 7'h66;  4'd5: s = 7'h6D;  4'd6: s = 7'h7D;  4'd7: s = 7'h07;
      4'd8: s = 7'h7F;  4'd9: s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after one rising edge, from the inputs present at that edge.
  // After the k-th edge since release, the digit shown is ((k-1)/RD) mod ND,
  // the frame is whatever was captured at the last multiple of FRAME edges,
  // and frame_done is high right after every multiple of FRAME.
  task automatic model_edge();
    int slot;
    logic [3:0] d;
    logic shown;
    if (!reset) begin
      m_e = 0; m_shadow = '0; m_frame = '0; m_err = 1'b0;
      e_an = '0; e_seg = '0; e_fd = 1'b0; e_err = 1'b0;
    end else begin
      m_e++;
      slot  = ((m_e - 1) / RD) % ND;
      d     = 4'(m_frame >> (4 * slot));
      e_seg = ref_seg(d);
      shown = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      shown = (slot == 0) || ((m_frame >> (4 * slot)) != 16'd0);
`endif
      e_an = (bus.blank || !shown) ? 4'b0000 : 4'(1 << slot);
      e_fd = (m_e % FRAME) == 0;
      if (e_fd) m_frame = m_shadow;
      if (bus.load) begin
        m_shadow = bus.bcd_in;
        for (int k = 0; k < ND; k++)
          if (((bus.bcd_in >> (4 * k)) & 16'hF) > 16'd9) m_err = 1'b1;
      end
      e_err = m_err;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("an",         32'(bus.an),         32'(e_an));
    check("seg",        32'(bus.seg),        32'(e_seg));
    check("frame_done", 32'(bus.frame_done), 32'(e_fd));
    check("err",        32'(bus.err),        32'(e_err));
  endtask

  // Advance until frame_done is seen, bounded by two frames.
  task automatic wait_fd();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      seen = bus.frame_done;
    end
    check("frame_done_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    int fd_count;
    logic [15:0] rnd;

    bus.bcd_in = '0;
    bus.load   = 1'b0;
    bus.blank  = 1'b0;
    reset      = 1'b0;

    // Reset held low, then release and first slot timing.
    repeat (3) tick();
    check("rst_an",  32'(bus.an),         32'd0);
    check("rst_seg", 32'(bus.seg),        32'd0);
    check("rst_fd",  32'(bus.frame_done), 32'd0);
    check("rst_err", 32'(bus.err),        32'd0);
    reset = 1'b1;
    tick();
    check("rel_an",  32'(bus.an),  32'h1);
    check("rel_seg", 32'(bus.seg), 32'h3F);
    repeat (3) tick();
    check("rel_an_hold", 32'(bus.an), 32'h1);
    tick();
    check("rel_an_next", 32'(bus.an), 32'h2);

    // Load 1234 just after a wrap; the next frame shows it slot by slot.
    wait_fd();
    bus.bcd_in = 16'h1234; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_fd();
    tick();
    check("f1234_an0",  32'(bus.an),  32'h1);
    check("f1234_seg0", 32'(bus.seg), 32'h66);
    repeat (RD) tick();
    check("f1234_an1",  32'(bus.an),  32'h2);
    check("f1234_seg1", 32'(bus.seg), 32'h4F);
    repeat (RD) tick();
    check("f1234_an2",  32'(bus.an),  32'h4);
    check("f1234_seg2", 32'(bus.seg), 32'h5B);
    repeat (RD) tick();
    check("f1234_an3",  32'(bus.an),  32'h8);
    check("f1234_seg3", 32'(bus.seg), 32'h06);

    // Free run: exactly one pulse per FRAME cycles, digit 0 enabled right after.
    fd_count = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if (bus.frame_done) begin
        fd_count++;
        tick();
        i++;
        check("an_after_fd", 32'(bus.an), 32'h1);
      end
    end
    check("fd_cadence", 32'(fd_count), 32'd4);

    // Non-BCD load sets sticky err and shows a dash; only reset clears it.
    wait_fd();
    bus.bcd_in = 16'h00A5; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("err_set", 32'(bus.err), 32'd1);
    wait_fd();
    tick();
    check("a5_seg0", 32'(bus.seg), 32'h6D);
    repeat (RD) tick();
    check("a5_seg1_dash", 32'(bus.seg), 32'h40);
    bus.bcd_in = 16'h0001; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("err_sticky", 32'(bus.err), 32'd1);
    repeat (20) tick();
    check("err_sticky_late", 32'(bus.err), 32'd1);
    reset = 1'b0;
    tick();
    check("err_cleared", 32'(bus.err), 32'd0);
    check("reset_an",    32'(bus.an),  32'd0);
    reset = 1'b1;
    tick();
    check("rerel_an",  32'(bus.an),  32'h1);
    check("rerel_seg", 32'(bus.seg), 32'h3F);

    // Load coincident with a wrap: old shadow shown one more frame.
    wait_fd();
    bus.bcd_in = 16'h0001; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 2 * FRAME && ((m_e + 1) % FRAME) != 0; i++) tick();
    bus.bcd_in = 16'h9999; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("wrap_load_fd", 32'(bus.frame_done), 32'd1);
    tick();
    check("wrap_load_old", 32'(bus.seg), 32'h06);
    wait_fd();
    tick();
    check("wrap_load_new", 32'(bus.seg), 32'h6F);

    // Blank forces enables off without disturbing the scan.
    bus.blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("blank_an", 32'(bus.an), 32'd0);
    end
    bus.blank = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    wait_fd();
    bus.bcd_in = 16'h0070; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_fd();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      check("lzb_upper_off", 32'(bus.an[3:2]), 32'd0);
    end
`endif

    // Randomized loads and blanking against the model.
    for (int i = 0; i < 400; i++) begin
      bus.load  = ($urandom_range(0, 7) == 0);
      bus.blank = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        rnd = 16'($urandom);
      end else begin
        for (int k = 0; k < ND; k++) rnd[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      bus.bcd_in = rnd;
      tick();
    end
    bus.load = 1'b0;
    bus.blank = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
